multicycle_decoder: RTL and testbench
=====================================

// Module: multicycle_decoder
// PURPOSE
//  Control unit for the multicycle ARM datapath: a Moore FSM that sequences each
//  instruction over 3-5 cycles, plus combinational ALU and immediate decoding.
//  Sits between the instruction register (Op, Funct, Rd) and the shared memory,
//  register-file and ALU control points; condlogic consumes PCS, NextPC, RegW,
//  MemW and FlagW. Extends the single-cycle decoder with EOR, CMP and TST, a memory
//  ready handshake and illegal-opcode recovery.
// PARAMETERS
//  EXT_OPS    1  1: decode EOR/CMP/TST; 0: base ADD/SUB/AND/ORR only, others illegal
//  ALUCTRL_W  3  ALUControl width; 2 legal only with EXT_OPS=0 (drop MSB)
// PORTS
//  clk         in   1  clock, rising edge
//  reset       in   1  asynchronous, active-high; state -> FETCH
//  Op          in   2  instr[27:26]
//  Funct       in   6  instr[25:20]: I, cmd[3:0], S
//  Rd          in   4  instr[15:12]
//  MemReady    in   1  memory has completed the current access this cycle
//  IRWrite     out  1  load instruction register
//  AdrSrc      out  1  0: address = PC, 1: address = ALUOut
//  NextPC      out  1  PC <- PC+4
//  RegW        out  1  register-file write (before condition gating)
//  MemW        out  1  memory write request
//  PCS         out  1  PC written by branch or by a write to R15
//  ResultSrc   out  2  00 ALUOut, 01 Data, 10 ALUResult
//  ALUSrcA     out  1  0 register A, 1 PC
//  ALUSrcB     out  2  00 register WriteData, 01 ExtImm, 10 constant 4
//  ImmSrc      out  2  00 DP imm8, 01 mem imm12, 10 branch imm24
//  RegSrc      out  2  bit0: Rn <- R15; bit1: Rm <- Rd (STR)
//  ALUControl  out  ALUCTRL_W  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR
//  FlagW       out  2  [1] write N,Z; [0] write C,V
//  Illegal     out  1  one-cycle pulse on unimplemented instruction
//  State       out  4  current state encoding, debug only
// BEHAVIOUR
//  States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, ILLEGAL.
//  Enable outputs (IRWrite, NextPC, RegW, MemW, PCS, FlagW, Illegal) are 0 in all states
//   unless listed below; they are forced 0 while reset=1. Reset mid-instruction aborts it
//   with no write; after release, first state is FETCH.
//  FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10; IRWrite=NextPC=MemReady;
//   stays in FETCH while MemReady=0, -> DECODE when MemReady=1.
//  DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (R15 = PC+8). Next: Op=01 -> MEMADR;
//   Op=00 & Funct[5] -> EXECI; Op=00 & !Funct[5] -> EXECR; Op=10 -> BRANCH;
//   Op=11 or illegal cmd -> ILLEGAL.
//  MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD; -> MEMRD if Funct[0] else MEMWR.
//  MEMRD: AdrSrc=1, ResultSrc=00; waits while MemReady=0; -> MEMWB.
//  MEMWR: AdrSrc=1, MemW=1 held every cycle until MemReady=1; -> FETCH.
//  MEMWB: ResultSrc=01, RegW=1; -> FETCH.
//  EXECR/EXECI: ALUSrcA=0, ALUSrcB=00/01, ALU decode active, FlagW valid; next ALUWB,
//   or FETCH directly for CMP/TST (no register write).
//  ALUWB: ResultSrc=00, RegW=1; -> FETCH.
//  BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ALUControl=ADD, PCS=1; -> FETCH.
//  ILLEGAL: Illegal=1 for exactly one cycle, no writes; -> FETCH.
//  PCS also =1 in MEMWB/ALUWB when Rd==4'b1111.
//  ALU decode (cmd=Funct[4:1]): 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR; EXT_OPS=1 adds
//   0001 EOR, 1010 CMP (SUB, S required), 1000 TST (AND, S required). CMP/TST with S=0
//   and any other cmd -> ILLEGAL. Outside EXEC states ALUControl=ADD.
//  FlagW[1]=S; FlagW[0]=S & (ADD|SUB|CMP); both 0 outside EXECR/EXECI.
//  ImmSrc/RegSrc combinational on Op in every state: DP 00/00, LDR 01/00, STR 01/10,
//   B 10/01, Op=11 00/00.
// TESTING
//  ADD imm (Op=00,Funct=101000), MemReady=1: FETCH,DECODE,EXECI,ALUWB; ALUControl=000,
//   RegW=1 in ALUWB only, FlagW=00.
//  LDR (Op=01,Funct=011001), MemReady low 2 cycles in MEMRD: MEMRD held 3 cycles, then
//   MEMWB with ResultSrc=01, RegW=1; STR holds MemW=1 until MemReady.
//  SUBS (Funct=000101) -> FlagW=11; CMP (Funct=010101) -> EXECR then FETCH, RegW never 1.
//  B (Op=10): BRANCH state PCS=1, ImmSrc=10, RegSrc=01; ADD with Rd=15 -> PCS=1 in ALUWB.
//  Op=11, and EOR with EXT_OPS=0: DECODE -> ILLEGAL, Illegal pulses 1 cycle, no writes.
//  reset asserted in MEMWR: MemW drops same cycle (async), State=FETCH after release.

Source files
------------

// File: rtl/multicycle_decoder.sv
// Multicycle ARM control unit: Moore sequencing FSM plus combinational ALU and
// immediate/register-source decode for the instruction held in the IR.
module multicycle_decoder #(
    parameter int EXT_OPS   = 1,
    parameter int ALUCTRL_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic                 MemReady,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic                 NextPC,
    output logic                 RegW,
    output logic                 MemW,
    output logic                 PCS,
    output logic [1:0]           ResultSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [1:0]           FlagW,
    output logic                 Illegal,
    output logic [3:0]           State
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ILLEGAL = 4'd10
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    localparam logic ext_en = (EXT_OPS != 0);

    state_t     state, state_next;
    logic [3:0] cmd;
    logic       s_bit;
    logic       dp_legal, dp_wb, dp_arith;
    logic [2:0] dp_alu, alu_ctrl;
    logic       irwrite_raw, nextpc_raw, regw_raw, memw_raw, pcs_raw, illegal_raw;
    logic [1:0] flagw_raw;
    logic       rd_is_pc;

    assign cmd      = Funct[4:1];
    assign s_bit    = Funct[0];
    assign rd_is_pc = (Rd == 4'b1111);

    // NOTE: every always_comb output gets a default first so no path leaves a
    // value held, which would otherwise infer a latch.
    always_comb begin
        dp_legal = 1'b1;
        dp_wb    = 1'b1;
        dp_arith = 1'b0;
        dp_alu   = ALU_ADD;
        case (cmd)
            4'b0100: begin dp_alu = ALU_ADD; dp_arith = 1'b1; end
            4'b0010: begin dp_alu = ALU_SUB; dp_arith = 1'b1; end
            4'b0000: dp_alu = ALU_AND;
            4'b1100: dp_alu = ALU_ORR;
            4'b0001: begin dp_alu = ALU_EOR; dp_legal = ext_en; end
            4'b1010: begin
                dp_alu   = ALU_SUB;
                dp_arith = 1'b1;
                dp_wb    = 1'b0;
                dp_legal = ext_en && s_bit;
            end
            4'b1000: begin
                dp_alu   = ALU_AND;
                dp_wb    = 1'b0;
                dp_legal = ext_en && s_bit;
            end
            default: dp_legal = 1'b0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        irwrite_raw = 1'b0;
        nextpc_raw  = 1'b0;
        regw_raw    = 1'b0;
        memw_raw    = 1'b0;
        pcs_raw     = 1'b0;
        illegal_raw = 1'b0;
        flagw_raw   = 2'b00;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        alu_ctrl    = ALU_ADD;
        case (state)
            S_FETCH: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                irwrite_raw = MemReady;
                nextpc_raw  = MemReady;
                if (MemReady) state_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b01:   state_next = S_MEMADR;
                    2'b00:   state_next = !dp_legal ? S_ILLEGAL :
                                          (Funct[5] ? S_EXECI : S_EXECR);
                    2'b10:   state_next = S_BRANCH;
                    default: state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB    = 2'b01;
                state_next = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                if (MemReady) state_next = S_MEMWB;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                memw_raw = 1'b1;
                if (MemReady) state_next = S_FETCH;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                regw_raw   = 1'b1;
                pcs_raw    = rd_is_pc;
                state_next = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB    = (state == S_EXECI) ? 2'b01 : 2'b00;
                alu_ctrl   = dp_alu;
                flagw_raw  = {s_bit, s_bit & dp_arith};
                state_next = dp_wb ? S_ALUWB : S_FETCH;
            end
            S_ALUWB: begin
                regw_raw   = 1'b1;
                pcs_raw    = rd_is_pc;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                pcs_raw    = 1'b1;
                state_next = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal_raw = 1'b1;
                state_next  = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Immediate and register-source selects depend only on the opcode class.
    always_comb begin
        ImmSrc = 2'b00;
        RegSrc = 2'b00;
        case (Op)
            2'b01: begin
                ImmSrc = 2'b01;
                RegSrc = Funct[0] ? 2'b00 : 2'b10;
            end
            2'b10: begin
                ImmSrc = 2'b10;
                RegSrc = 2'b01;
            end
            default: ;
        endcase
    end

    // Enables drop combinationally with reset so an aborted access never writes.
    assign IRWrite    = irwrite_raw & ~reset;
    assign NextPC     = nextpc_raw & ~reset;
    assign RegW       = regw_raw & ~reset;
    assign MemW       = memw_raw & ~reset;
    assign PCS        = pcs_raw & ~reset;
    assign Illegal    = illegal_raw & ~reset;
    assign FlagW      = flagw_raw & {2{~reset}};
    assign ALUControl = alu_ctrl[ALUCTRL_W-1:0];
    assign State      = state;

endmodule

// File: tb/tb_multicycle_decoder.sv
// Bench for multicycle_decoder: instruction-level model of the control sequence,
// driven by directed and $urandom instructions on an extended and a base instance.
module tb_multicycle_decoder;

    typedef struct packed {
        logic       irwrite;
        logic       adrsrc;
        logic       nextpc;
        logic       regw;
        logic       memw;
        logic       pcs;
        logic [1:0] resultsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] immsrc;
        logic [1:0] regsrc;
        logic [2:0] aluctrl;
        logic [1:0] flagw;
        logic       illegal;
    } ctl_t;

    typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                  P_EXECR, P_EXECI, P_ALUWB, P_BRANCH, P_ILLEGAL} phase_t;

    typedef struct {
        logic [3:0] cmd;
        logic [2:0] alu;
        bit         ext;
        bit         need_s;
        bit         wb;
        bit         cv;
    } op_ent_t;

    // Data-processing instruction table: cmd, ALU op, extension-only, S required,
    // writes Rd, updates C/V.
    op_ent_t optab [7] = '{
        '{4'b0100, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1},
        '{4'b0010, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1},
        '{4'b0000, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0},
        '{4'b1100, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0},
        '{4'b0001, 3'b100, 1'b1, 1'b0, 1'b1, 1'b0},
        '{4'b1010, 3'b001, 1'b1, 1'b1, 1'b0, 1'b1},
        '{4'b1000, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0}
    };

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       MemReady;

    logic       a_irwrite, a_adrsrc, a_nextpc, a_regw, a_memw, a_pcs, a_alusrca, a_illegal;
    logic [1:0] a_resultsrc, a_alusrcb, a_immsrc, a_regsrc, a_flagw;
    logic [2:0] a_aluctrl;
    logic [3:0] a_state;
    logic       b_irwrite, b_adrsrc, b_nextpc, b_regw, b_memw, b_pcs, b_alusrca, b_illegal;
    logic [1:0] b_resultsrc, b_alusrcb, b_immsrc, b_regsrc, b_flagw;
    logic [1:0] b_aluctrl;
    logic [3:0] b_state;

    ctl_t obs_a, obs_b;
    int   n_assert = 0;
    int   n_fail   = 0;
    bit   use_b    = 1'b0;
    bit   ext_mode = 1'b1;

    always #5 clk = ~clk;

    multicycle_decoder #(.EXT_OPS(1), .ALUCTRL_W(3)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .MemReady(MemReady),
        .IRWrite(a_irwrite), .AdrSrc(a_adrsrc), .NextPC(a_nextpc), .RegW(a_regw),
        .MemW(a_memw), .PCS(a_pcs), .ResultSrc(a_resultsrc), .ALUSrcA(a_alusrca),
        .ALUSrcB(a_alusrcb), .ImmSrc(a_immsrc), .RegSrc(a_regsrc), .ALUControl(a_aluctrl),
        .FlagW(a_flagw), .Illegal(a_illegal), .State(a_state)
    );

    multicycle_decoder #(.EXT_OPS(0), .ALUCTRL_W(2)) dut_base (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .MemReady(MemReady),
        .IRWrite(b_irwrite), .AdrSrc(b_adrsrc), .NextPC(b_nextpc), .RegW(b_regw),
        .MemW(b_memw), .PCS(b_pcs), .ResultSrc(b_resultsrc), .ALUSrcA(b_alusrca),
        .ALUSrcB(b_alusrcb), .ImmSrc(b_immsrc), .RegSrc(b_regsrc), .ALUControl(b_aluctrl),
        .FlagW(b_flagw), .Illegal(b_illegal), .State(b_state)
    );

    assign obs_a = {a_irwrite, a_adrsrc, a_nextpc, a_regw, a_memw, a_pcs, a_resultsrc,
                    a_alusrca, a_alusrcb, a_immsrc, a_regsrc, a_aluctrl, a_flagw, a_illegal};
    assign obs_b = {b_irwrite, b_adrsrc, b_nextpc, b_regw, b_memw, b_pcs, b_resultsrc,
                    b_alusrca, b_alusrcb, b_immsrc, b_regsrc, {1'b0, b_aluctrl}, b_flagw,
                    b_illegal};

    task automatic check(input string tag, input ctl_t observed, input ctl_t expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic ctl_t enable_mask();
        ctl_t m;
        m = '0;
        m.irwrite = 1'b1; m.nextpc = 1'b1; m.regw = 1'b1; m.memw = 1'b1;
        m.pcs = 1'b1; m.flagw = 2'b11; m.illegal = 1'b1;
        return m;
    endfunction

    function automatic bit dp_lookup(input logic [5:0] f, input bit ext,
                                     output logic [2:0] alu, output bit wb, output bit cv);
        alu = 3'b000; wb = 1'b0; cv = 1'b0;
        foreach (optab[i]) begin
            if (optab[i].cmd == f[4:1] && (!optab[i].ext || ext) &&
                (!optab[i].need_s || f[0])) begin
                alu = optab[i].alu; wb = optab[i].wb; cv = optab[i].cv;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Expected outputs for one cycle of the given phase; m marks the fields that
    // the phase defines (all enables, selects and ALU control always count).
    function automatic void expect_ctl(input phase_t ph, input logic mr,
                                       output ctl_t e, output ctl_t m);
        logic [2:0] alu;
        bit wb, cv, legal;
        e = '0;
        m = enable_mask();
        m.immsrc = 2'b11; m.regsrc = 2'b11; m.aluctrl = 3'b111;
        if (Op == 2'b01) begin
            e.immsrc = 2'b01;
            e.regsrc = Funct[0] ? 2'b00 : 2'b10;
        end else if (Op == 2'b10) begin
            e.immsrc = 2'b10;
            e.regsrc = 2'b01;
        end
        case (ph)
            P_FETCH, P_DECODE: begin
                e.alusrca = 1'b1; e.alusrcb = 2'b10; e.resultsrc = 2'b10;
                m.alusrca = 1'b1; m.alusrcb = 2'b11; m.resultsrc = 2'b11;
                if (ph == P_FETCH) begin
                    e.irwrite = mr; e.nextpc = mr; m.adrsrc = 1'b1;
                end
            end
            P_MEMADR: begin
                e.alusrcb = 2'b01; m.alusrca = 1'b1; m.alusrcb = 2'b11;
            end
            P_MEMRD: begin
                e.adrsrc = 1'b1; m.adrsrc = 1'b1; m.resultsrc = 2'b11;
            end
            P_MEMWR: begin
                e.adrsrc = 1'b1; e.memw = 1'b1; m.adrsrc = 1'b1;
            end
            P_MEMWB, P_ALUWB: begin
                e.resultsrc = (ph == P_MEMWB) ? 2'b01 : 2'b00;
                e.regw = 1'b1; e.pcs = (Rd == 4'd15);
                m.resultsrc = 2'b11;
            end
            P_EXECR, P_EXECI: begin
                legal = dp_lookup(Funct, ext_mode, alu, wb, cv);
                e.aluctrl = legal ? alu : 3'bxxx;
                e.flagw = {Funct[0], Funct[0] & cv};
                e.alusrcb = (ph == P_EXECI) ? 2'b01 : 2'b00;
                m.alusrca = 1'b1; m.alusrcb = 2'b11;
            end
            P_BRANCH: begin
                e.alusrcb = 2'b01; e.resultsrc = 2'b10; e.pcs = 1'b1;
                m.alusrca = 1'b1; m.alusrcb = 2'b11; m.resultsrc = 2'b11;
            end
            P_ILLEGAL: e.illegal = 1'b1;
            default: ;
        endcase
    endfunction

    // Called at posedge+1; drives MemReady, checks at the falling edge.
    task automatic step(input phase_t ph, input logic mr, input string tag);
        ctl_t e, m, o;
        MemReady = mr;
        @(negedge clk);
        expect_ctl(ph, mr, e, m);
        o = use_b ? obs_b : obs_a;
        check($sformatf("%s/%s", tag, ph.name()), o & m, e & m);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                             input int fs, input int ms, input string tag);
        logic [2:0] alu;
        bit wb, cv, legal;
        Op = op; Funct = f; Rd = rd;
        repeat (fs) step(P_FETCH, 1'b0, tag);
        step(P_FETCH, 1'b1, tag);
        step(P_DECODE, rnd_bit(), tag);
        legal = dp_lookup(f, ext_mode, alu, wb, cv);
        case (op)
            2'b00: begin
                if (!legal) step(P_ILLEGAL, rnd_bit(), tag);
                else begin
                    step(f[5] ? P_EXECI : P_EXECR, rnd_bit(), tag);
                    if (wb) step(P_ALUWB, rnd_bit(), tag);
                end
            end
            2'b01: begin
                step(P_MEMADR, rnd_bit(), tag);
                if (f[0]) begin
                    repeat (ms) step(P_MEMRD, 1'b0, tag);
                    step(P_MEMRD, 1'b1, tag);
                    step(P_MEMWB, rnd_bit(), tag);
                end else begin
                    repeat (ms) step(P_MEMWR, 1'b0, tag);
                    step(P_MEMWR, 1'b1, tag);
                end
            end
            2'b10: step(P_BRANCH, rnd_bit(), tag);
            default: step(P_ILLEGAL, rnd_bit(), tag);
        endcase
    endtask

    task automatic random_instr(input string tag);
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] rd;
        op = 2'($urandom_range(0, 3));
        f  = 6'($urandom);
        if (op == 2'b00 && $urandom_range(0, 3) != 0)
            f[4:1] = optab[$urandom_range(0, 6)].cmd;
        rd = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom);
        run_instr(op, f, rd, $urandom_range(0, 2), $urandom_range(0, 3), tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1; MemReady = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "/enables_in_reset"},
              (use_b ? obs_b : obs_a) & enable_mask(), '0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; Op = 2'b00; Funct = 6'b0; Rd = 4'd0; MemReady = 1'b0;
        #1;
        do_reset("reset");

        run_instr(2'b00, 6'b101000, 4'd3, 0, 0, "add_imm");
        run_instr(2'b01, 6'b011001, 4'd2, 1, 2, "ldr");
        run_instr(2'b01, 6'b011000, 4'd2, 0, 2, "str");
        run_instr(2'b00, 6'b000101, 4'd4, 0, 0, "subs");
        run_instr(2'b00, 6'b010101, 4'd5, 2, 0, "cmp");
        run_instr(2'b00, 6'b010001, 4'd5, 0, 0, "tst");
        run_instr(2'b00, 6'b000010, 4'd6, 0, 0, "eor");
        run_instr(2'b00, 6'b111001, 4'd7, 0, 0, "orrs_imm");
        run_instr(2'b10, 6'b100000, 4'd0, 0, 0, "branch");
        run_instr(2'b00, 6'b101000, 4'd15, 0, 0, "add_pc");
        run_instr(2'b01, 6'b011001, 4'd15, 0, 1, "ldr_pc");
        run_instr(2'b11, 6'b000000, 4'd1, 0, 0, "op11");
        run_instr(2'b00, 6'b010100, 4'd1, 0, 0, "cmp_nos");
        run_instr(2'b00, 6'b001110, 4'd1, 0, 0, "bad_cmd");

        // Reset while a store is waiting on memory: MemW must fall at once.
        Op = 2'b01; Funct = 6'b011000; Rd = 4'd2;
        step(P_FETCH, 1'b1, "str_abort");
        step(P_DECODE, 1'b1, "str_abort");
        step(P_MEMADR, 1'b1, "str_abort");
        step(P_MEMWR, 1'b0, "str_abort");
        MemReady = 1'b0;
        #2;
        check("str_abort/memw_before", obs_a & enable_mask(), ctl_t'(22'h0) | ctl_t'({4'b0, 1'b1, 16'b0}));
        reset = 1'b1;
        #1;
        check("str_abort/memw_async_drop", obs_a & enable_mask(), '0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr(2'b00, 6'b101000, 4'd3, 1, 0, "after_abort");

        for (int i = 0; i < 80; i++) random_instr("rand_ext");

        // Base configuration: extension opcodes must trap as illegal.
        use_b = 1'b1; ext_mode = 1'b0;
        do_reset("base_reset");
        run_instr(2'b00, 6'b000010, 4'd6, 0, 0, "base_eor");
        run_instr(2'b00, 6'b010101, 4'd6, 0, 0, "base_cmp");
        run_instr(2'b00, 6'b010001, 4'd6, 0, 0, "base_tst");
        run_instr(2'b00, 6'b000101, 4'd6, 0, 0, "base_subs");
        run_instr(2'b00, 6'b111000, 4'd15, 0, 0, "base_orr_pc");
        for (int i = 0; i < 30; i++) random_instr("rand_base");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
